// File: rtl/progmem_access_arbiter_if.sv
// Bundle of requester and program-memory signals seen by progmem_access_arbiter.
// Handshake: a requester raises *_req with its address and holds both stable until the matching
// one-cycle *_ack; *_data is valid in the ack cycle and holds until that requester's next ack.
interface progmem_access_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [15:0]       fetch_data;

  logic              lpm_req;
  logic [ADDR_W:0]   lpm_addr;
  logic              lpm_ack;
  logic [7:0]        lpm_data;

  logic              pp_req;
  logic [ADDR_W-1:0] pp_addr;
  logic              pp_hibyte;
  logic              pp_ack;
  logic [7:0]        pp_data;

  logic              prog_mode;
  logic              rww_busy;
  logic              rww_blocked;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, lpm_req, lpm_addr, pp_req, pp_addr, pp_hibyte,
           prog_mode, rww_busy, mem_rdata,
    output fetch_ack, fetch_data, lpm_ack, lpm_data, pp_ack, pp_data,
           rww_blocked, mem_rd, mem_addr
  );

  modport master (
    output fetch_req, fetch_addr, lpm_req, lpm_addr, pp_req, pp_addr, pp_hibyte,
           prog_mode, rww_busy, mem_rdata,
    input  fetch_ack, fetch_data, lpm_ack, lpm_data, pp_ack, pp_data,
           rww_blocked, mem_rd, mem_addr
  );
endinterface

// File: rtl/progmem_access_arbiter.sv
// Single-port program-memory read arbiter: fixed priority pp > lpm > fetch, RWW read blocking,
// one read per IDLE -> READ -> CAPTURE pass with the ack landing in the following IDLE cycle.
module progmem_access_arbiter #(
  parameter int                ADDR_W    = 14,
  parameter logic [ADDR_W-1:0] NRWW_BASE = 14'h3800
) (
  input  logic                     clk,
  input  logic                     rst_n,
  progmem_access_arbiter_if.slave  bus,
  output logic [1:0]               dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, CAPTURE = 2'd2} state_t;
  typedef enum logic [1:0] {GNT_NONE = 2'd0, GNT_FETCH = 2'd1, GNT_LPM = 2'd2, GNT_PP = 2'd3} grant_t;

  state_t            state_q, state_d;
  grant_t            grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hib_q, hib_d;

  logic              fetch_ack_q, lpm_ack_q, pp_ack_q;
  logic [15:0]       fetch_data_q;
  logic [7:0]        lpm_data_q, pp_data_q;

  logic [ADDR_W-1:0] lpm_word;
  logic              fetch_in_rww, lpm_in_rww;
  logic              fetch_ok, lpm_ok, pp_ok;
  logic [7:0]        capture_byte;

  assign lpm_word     = bus.lpm_addr[ADDR_W:1];
  assign fetch_in_rww = (bus.fetch_addr < NRWW_BASE);
  assign lpm_in_rww   = (lpm_word < NRWW_BASE);

  // A requester whose ack is on the bus this cycle still has req high; it must not be re-granted.
  assign pp_ok    = bus.pp_req & bus.prog_mode & ~pp_ack_q;
  assign lpm_ok   = bus.lpm_req & ~bus.prog_mode & ~lpm_ack_q & ~(bus.rww_busy & lpm_in_rww);
  assign fetch_ok = bus.fetch_req & ~bus.prog_mode & ~fetch_ack_q & ~(bus.rww_busy & fetch_in_rww);

  assign capture_byte = hib_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    hib_d   = hib_q;
    case (state_q)
      IDLE: begin
        if (pp_ok) begin
          grant_d = GNT_PP;
          addr_d  = bus.pp_addr;
          hib_d   = bus.pp_hibyte;
          state_d = READ;
        end else if (lpm_ok) begin
          grant_d = GNT_LPM;
          addr_d  = lpm_word;
          hib_d   = bus.lpm_addr[0];
          state_d = READ;
        end else if (fetch_ok) begin
          grant_d = GNT_FETCH;
          addr_d  = bus.fetch_addr;
          hib_d   = 1'b0;
          state_d = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= GNT_NONE;
      addr_q       <= '0;
      hib_q        <= 1'b0;
      fetch_ack_q  <= 1'b0;
      lpm_ack_q    <= 1'b0;
      pp_ack_q     <= 1'b0;
      fetch_data_q <= '0;
      lpm_data_q   <= '0;
      pp_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      hib_q       <= hib_d;
      fetch_ack_q <= 1'b0;
      lpm_ack_q   <= 1'b0;
      pp_ack_q    <= 1'b0;
      // mem_rdata is valid in CAPTURE, one cycle after the READ strobe.
      if (state_q == CAPTURE) begin
        case (grant_q)
          GNT_FETCH: begin
            fetch_ack_q  <= 1'b1;
            fetch_data_q <= bus.mem_rdata;
          end
          GNT_LPM: begin
            lpm_ack_q  <= 1'b1;
            lpm_data_q <= capture_byte;
          end
          GNT_PP: begin
            pp_ack_q  <= 1'b1;
            pp_data_q <= capture_byte;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_rd      = (state_q == READ);
  assign bus.mem_addr    = addr_q;
  assign bus.fetch_ack   = fetch_ack_q;
  assign bus.fetch_data  = fetch_data_q;
  assign bus.lpm_ack     = lpm_ack_q;
  assign bus.lpm_data    = lpm_data_q;
  assign bus.pp_ack      = pp_ack_q;
  assign bus.pp_data     = pp_data_q;
  assign bus.rww_blocked = bus.rww_busy & ~bus.prog_mode &
                           ((bus.fetch_req & fetch_in_rww) | (bus.lpm_req & lpm_in_rww));
  assign dbg_state       = state_q;

endmodule

// File: doc/progmem_access_arbiter.md
Name: progmem_access_arbiter

Overview:
- Single-port read arbiter and sequencer in front of the 32 KB program memory (256 rows x 128 bytes; 14-bit word address).
- Requesters: core instruction fetch (16-bit word), LPM data read (byte), and parallel-programming read (byte, active only in programming mode).
- Enforces RWW/NRWW read-while-write rules during self-programming.
- Issues one memory read at a time and returns data with a fixed handshake.

Parameters:
- ADDR_W, 14, word-address width of program memory.
- NRWW_BASE, 14'h3800, first word address of the NRWW section (rows 224-255); addresses below it are RWW.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch request; held high until fetch_ack.
- fetch_addr  in  14  fetch word address (PC).
- fetch_ack  out  1  one-cycle pulse; fetch_data valid in the same cycle.
- fetch_data  out  16  fetched instruction word.
- lpm_req  in  1  LPM request; held high until lpm_ack.
- lpm_addr  in  15  LPM byte address; bit 0 = 1 selects the high byte.
- lpm_ack  out  1  one-cycle pulse; lpm_data valid in the same cycle.
- lpm_data  out  8  LPM byte.
- pp_req  in  1  parallel-programming read request; held high until pp_ack.
- pp_addr  in  14  word address latched by the programming interface.
- pp_hibyte  in  1  1 selects the high byte.
- pp_ack  out  1  one-cycle pulse.
- pp_data  out  8  read byte.
- prog_mode  in  1  1 selects programming mode.
- rww_busy  in  1  1 while an RWW erase or write is in progress.
- mem_rd  out  1  one-cycle memory read strobe.
- mem_addr  out  14  memory word address.
- mem_rdata  in  16  memory read data; valid the cycle after mem_rd.
- rww_blocked  out  1  a core request targets RWW while rww_busy=1.

Behaviour:
- Reset: state IDLE. mem_rd, mem_addr, all ack outputs, all data outputs, rww_blocked and the internal grant register are 0.
- Reset asserted mid-transaction aborts it immediately, with no ack.
- States:
  - IDLE: sample the requests. If a requester is eligible, latch its address, byte select and grant ID, then go to READ.
  - READ: mem_rd=1, mem_addr=latched address. Go to CAPTURE.
  - CAPTURE: register mem_rdata into the granted requester's data output. Set its ack to 1 for the next cycle. Go to IDLE.
- Latency: request sampled in IDLE at cycle N produces ack in cycle N+3. Back-to-back throughput is one read per 3 cycles.
- The ack cycle is spent in IDLE and can grant a different requester. The requester that is being acked is masked from arbitration in that cycle.
- Eligibility:
  - prog_mode=1: only pp_req is eligible. fetch_req and lpm_req are never acked.
  - prog_mode=0: pp_req is ignored.
  - A fetch or LPM request is ineligible when rww_busy=1 and its word address (fetch_addr, or lpm_addr[14:1]) < NRWW_BASE.
- Priority, fixed: pp > lpm > fetch. Fetch may starve under continuous LPM; this is accepted because the core stalls on LPM.
- Byte select:
  - LPM: lpm_addr[0]=0 returns mem_rdata[7:0]; 1 returns mem_rdata[15:8].
  - PP: pp_hibyte selects the byte the same way.
- Data outputs hold their last value until the next ack to the same requester.
- rww_blocked is combinational. It is 1 in any cycle where rww_busy=1, prog_mode=0, and a pending fetch or LPM request targets RWW.
- rww_busy rising or prog_mode toggling mid-transaction (READ/CAPTURE): the transaction completes and acks normally. The new rule applies at the next IDLE sample.
- Request inputs are sampled only in IDLE. Address changes during READ/CAPTURE are ignored.

Test Plan:
- Reset then fetch: memory word 0x0041 holds 16'h6699; fetch_req=1 with fetch_addr=0x0041 → mem_rd at N+1 with mem_addr=0x0041; fetch_ack at N+3 with fetch_data=16'h6699. Assert rst_n=0 mid-READ → all outputs 0, no ack.
- LPM byte select: lpm_addr=15'h0083 → lpm_data=8'h66; lpm_addr=15'h0082 → lpm_data=8'h99.
- Simultaneous fetch and LPM at cycle N: LPM acked at N+3. The same IDLE cycle grants fetch (LPM masked), so fetch is acked at N+6 (three cycles later).
- RWW block: rww_busy=1 with fetch_addr=0x0041 → rww_blocked=1 and no mem_rd. Change fetch_addr to 0x3841 (word 16'hF69F) → fetch_ack with 16'hF69F. Drop rww_busy with fetch_addr=0x0041 → the fetch completes.
- Programming mode: prog_mode=1, fetch_req=1, pp_req=1 with pp_addr=0x3841 and pp_hibyte=1 → pp_data=8'hF6, pp_ack pulses, fetch is never acked. Repeat with pp_hibyte=0 → pp_data=8'h9F.
- Mode toggle: set prog_mode=1 during READ of a fetch → the fetch still acks. The following pp request is served next.
